// File: rtl/prio_arbiter_pkg.sv
// Shared types, mode constants and index arithmetic for the round-robin arbiter.
package prio_arbiter_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // (a + b) mod n, valid while both operands are already below n.
    function automatic int unsigned wrap_inc(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/prio_arbiter_rr_if.sv
// Request/grant bundle between the requesters' side (master) and the arbiter (slave).
interface prio_arbiter_rr_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;
    logic [W-1:0] ptr;

    modport master (
        output en, mode, req, gnt_ready,
        input  gnt_valid, gnt_idx, gnt_onehot, ptr
    );

    modport slave (
        input  en, mode, req, gnt_ready,
        output gnt_valid, gnt_idx, gnt_onehot, ptr
    );
endinterface

// File: rtl/prio_enc_core.sv
// Combinational N-input priority encoder: highest set index wins.
module prio_enc_core #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    // Scan upward so the last (highest) set bit overwrites earlier ones.
    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        for (int i = 0; i < N; i++) begin
            o_idx = i_req[i] ? W'(i) : o_idx;
        end
    end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-input arbiter with fixed-priority / round-robin modes and a
// valid/ready grant that is held until accepted.
module prio_arbiter_rr
    import prio_arbiter_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    prio_arbiter_rr_if.slave bus
);

    localparam logic [N-1:0] ONEHOT_LSB = N'(1);

    state_t       r_state, w_state_nxt;
    logic         r_gnt_valid, w_gnt_valid_nxt;
    logic [W-1:0] r_gnt_idx, w_gnt_idx_nxt;
    logic [N-1:0] r_gnt_onehot, w_gnt_onehot_nxt;
    logic         r_gnt_mode, w_gnt_mode_nxt;
    logic [W-1:0] r_ptr, w_ptr_nxt;

    logic         w_accept;
    int unsigned  w_rot_base;
    logic [N-1:0] w_req_rot;
    logic [W-1:0] w_enc_idx;
    logic         w_enc_any;
    logic [W-1:0] w_winner;

    // Pointer after this edge's acceptance; a granted index drops to lowest priority.
    always_comb begin
        w_accept  = r_gnt_valid & bus.gnt_ready;
        w_ptr_nxt = r_ptr;
        if (w_accept && (r_gnt_mode == MODE_RR)) begin
            w_ptr_nxt = (r_gnt_idx == '0) ? W'(N - 1) : (r_gnt_idx - W'(1));
        end else begin
            w_ptr_nxt = r_ptr;
        end
    end

    // Rotate req so the pointer lands on index N-1; fixed mode uses no rotation.
    always_comb begin
        w_rot_base = (bus.mode == MODE_RR) ? wrap_inc(int'(w_ptr_nxt), 32'd1, N) : 32'd0;
        w_req_rot  = '0;
        for (int j = 0; j < N; j++) begin
            w_req_rot[j] = bus.req[wrap_inc(j, w_rot_base, N)];
        end
    end

    prio_enc_core #(
        .N (N),
        .W (W)
    ) u_enc (
        .i_req (w_req_rot),
        .o_idx (w_enc_idx),
        .o_any (w_enc_any)
    );

    // Map the encoder's position in the rotated vector back to a requester index.
    always_comb begin
        w_winner = W'(wrap_inc(int'(w_enc_idx), w_rot_base, N));
    end

    // Next-state and next-output decode; a pending grant ignores req/en/mode.
    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_valid_nxt  = r_gnt_valid;
        w_gnt_idx_nxt    = r_gnt_idx;
        w_gnt_onehot_nxt = r_gnt_onehot;
        w_gnt_mode_nxt   = r_gnt_mode;
        case (r_state)
            IDLE: begin
                if (bus.en && w_enc_any) begin
                    w_state_nxt      = GRANT;
                    w_gnt_valid_nxt  = 1'b1;
                    w_gnt_idx_nxt    = w_winner;
                    w_gnt_onehot_nxt = ONEHOT_LSB << w_winner;
                    w_gnt_mode_nxt   = bus.mode;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (w_accept && bus.en && w_enc_any) begin
                    w_state_nxt      = GRANT;
                    w_gnt_valid_nxt  = 1'b1;
                    w_gnt_idx_nxt    = w_winner;
                    w_gnt_onehot_nxt = ONEHOT_LSB << w_winner;
                    w_gnt_mode_nxt   = bus.mode;
                end else if (w_accept) begin
                    w_state_nxt      = IDLE;
                    w_gnt_valid_nxt  = 1'b0;
                    w_gnt_idx_nxt    = '0;
                    w_gnt_onehot_nxt = '0;
                end else begin
                    w_state_nxt = GRANT;
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_gnt_valid_nxt  = 1'b0;
                w_gnt_idx_nxt    = '0;
                w_gnt_onehot_nxt = '0;
            end
        endcase
    end

    // State, grant and pointer registers; reset leaves RR equivalent to fixed priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt_valid  <= 1'b0;
            r_gnt_idx    <= '0;
            r_gnt_onehot <= '0;
            r_gnt_mode   <= MODE_FIXED;
            r_ptr        <= W'(N - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_gnt_valid  <= w_gnt_valid_nxt;
            r_gnt_idx    <= w_gnt_idx_nxt;
            r_gnt_onehot <= w_gnt_onehot_nxt;
            r_gnt_mode   <= w_gnt_mode_nxt;
            r_ptr        <= w_ptr_nxt;
        end
    end

    assign bus.gnt_valid  = r_gnt_valid;
    assign bus.gnt_idx    = r_gnt_idx;
    assign bus.gnt_onehot = r_gnt_onehot;
    assign bus.ptr        = r_ptr;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Directed bench for prio_arbiter_rr with a per-cycle reference model.
module tb_prio_arbiter_rr;
    localparam int N = 8;
    localparam int W = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    bit   chk_on;

    prio_arbiter_rr_if #(.N(N), .W(W)) bus();

    prio_arbiter_rr #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: winner found by walking the search order directly.
    bit m_valid;
    int m_idx;
    int m_ptr;
    bit m_gmode;

    function automatic int pick(input logic [N-1:0] r, input bit md, input int p);
        if (!md) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (p - k + N) % N;
                if (r[c]) return c;
            end
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = N - 1;
            m_gmode = 1'b0;
        end else begin
            bit acc;
            acc = m_valid && bus.gnt_ready;
            if (acc && m_gmode) m_ptr = (m_idx + N - 1) % N;
            if ((!m_valid || acc) && bus.en && (bus.req != '0)) begin
                m_idx   = pick(bus.req, bus.mode, m_ptr);
                m_gmode = bus.mode;
                m_valid = 1'b1;
            end else if (acc) begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_valid",  32'(bus.gnt_valid),  32'(m_valid));
            chk("cmp_idx",    32'(bus.gnt_idx),    m_valid ? m_idx : 0);
            chk("cmp_onehot", 32'(bus.gnt_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
            chk("cmp_ptr",    32'(bus.ptr),        m_ptr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rr_exp [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    int sp_exp [4]  = '{0, 7, 0, 7};

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        chk_on        = 1'b0;
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.mode      = 1'b0;
        bus.req       = 8'hFF;
        bus.gnt_ready = 1'b0;

        // Reset state
        step();
        chk_on = 1'b1;
        chk("rst_valid",  32'(bus.gnt_valid),  32'd0);
        chk("rst_idx",    32'(bus.gnt_idx),    32'd0);
        chk("rst_onehot", 32'(bus.gnt_onehot), 32'd0);
        chk("rst_ptr",    32'(bus.ptr),        32'd7);
        rst_n  = 1'b1;
        bus.en = 1'b1;
        step();
        chk("first_idx",    32'(bus.gnt_idx),    32'd7);
        chk("first_onehot", 32'(bus.gnt_onehot), 32'h80);
        chk("first_valid",  32'(bus.gnt_valid),  32'd1);

        // Fixed-mode hold
        bus.gnt_ready = 1'b1;
        bus.req       = 8'b0010_0100;
        step();
        chk("fix_load", 32'(bus.gnt_idx), 32'd5);
        bus.gnt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.req = 8'h80;
            step();
            chk("fix_hold", 32'(bus.gnt_idx), 32'd5);
            chk("fix_hold_valid", 32'(bus.gnt_valid), 32'd1);
        end
        bus.gnt_ready = 1'b1;
        step();
        chk("fix_next", 32'(bus.gnt_idx), 32'd7);
        chk("fix_ptr",  32'(bus.ptr),     32'd7);

        // Drain to idle, then round-robin fairness
        bus.req = 8'h00;
        step();
        chk("idle_valid", 32'(bus.gnt_valid), 32'd0);
        bus.mode = 1'b1;
        bus.req  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rr_idx",   32'(bus.gnt_idx),   rr_exp[i]);
            chk("rr_valid", 32'(bus.gnt_valid), 32'd1);
        end

        // Sparse wrap
        bus.req = 8'b1000_0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sp_idx", 32'(bus.gnt_idx), sp_exp[i]);
            if (sp_exp[i] == 7) chk("sp_ptr", 32'(bus.ptr), 32'd7);
        end

        // Enable gating, then reset while a grant is pending
        bus.req = 8'h00;
        step();
        bus.en  = 1'b0;
        bus.req = 8'h10;
        step();
        chk("en0_valid_a", 32'(bus.gnt_valid), 32'd0);
        step();
        chk("en0_valid_b", 32'(bus.gnt_valid), 32'd0);
        bus.en        = 1'b1;
        bus.gnt_ready = 1'b0;
        step();
        chk("en1_idx",   32'(bus.gnt_idx),   32'd4);
        chk("en1_valid", 32'(bus.gnt_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid",  32'(bus.gnt_valid),  32'd0);
        chk("rstmid_onehot", 32'(bus.gnt_onehot), 32'd0);
        chk("rstmid_ptr",    32'(bus.ptr),        32'd7);
        step();
        rst_n = 1'b1;

        // Mixed directed pattern, checked by the model every cycle
        for (int i = 0; i < 40; i++) begin
            bus.req       = 8'((i * 37 + 5) & 255);
            bus.mode      = ((i / 4) % 2) == 1;
            bus.en        = (i % 5) != 0;
            bus.gnt_ready = (i % 3) != 1;
            step();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
